// File: rtl/wc_tile_streamer.sv
// Streams samples into an 8-wide overlapping window (stride 6), hands each full tile
// to an attached WC core, waits a fixed latency, then serializes its 6 results.
module wc_tile_streamer #(
    parameter int DW     = 10,
    parameter int WC_LAT = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DW-1:0]     s_data,
    input  logic              s_first,
    output logic [8*DW-1:0]   D_out,
    input  logic [6*DW-1:0]   Z_in,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DW-1:0]     m_data,
    output logic [15:0]       tile_cnt
);

    typedef enum logic [1:0] {FILL, WAIT, DRAIN} state_t;

    state_t                 state_q, state_d;
    logic [7:0][DW-1:0]     win_q, win_d;
    logic [3:0]             fill_q, fill_d;
    logic [8*DW-1:0]        dout_q, dout_d;
    logic [3:0]             lat_q, lat_d;
    logic [5:0][DW-1:0]     obuf_q, obuf_d;
    logic [2:0]             ridx_q, ridx_d;
    logic [15:0]            tcnt_q, tcnt_d;

    assign s_ready  = (state_q == FILL);
    assign m_valid  = (state_q == DRAIN);
    assign m_data   = obuf_q[ridx_q];
    assign D_out    = dout_q;
    assign tile_cnt = tcnt_q;

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        fill_d  = fill_q;
        dout_d  = dout_q;
        lat_d   = lat_q;
        obuf_d  = obuf_q;
        ridx_d  = ridx_q;
        tcnt_d  = tcnt_q;
        case (state_q)
            FILL: begin
                if (s_valid) begin
                    if (s_first) begin
                        win_d[0] = s_data;
                        fill_d   = 4'd1;
                    end else begin
                        win_d[fill_q[2:0]] = s_data;
                        if (fill_q == 4'd7) begin
                            // Sample 0 lands in the MSBs of D_out.
                            for (int i = 0; i < 8; i++)
                                dout_d[8*DW-1-i*DW -: DW] = win_d[i];
                            // Last two samples seed the next tile (stride 6).
                            win_d[0] = win_q[6];
                            win_d[1] = s_data;
                            fill_d   = 4'd2;
                            lat_d    = 4'(WC_LAT);
                            state_d  = WAIT;
                        end else begin
                            fill_d = fill_q + 4'd1;
                        end
                    end
                end
            end
            WAIT: begin
                if (lat_q == 4'd0) begin
                    for (int k = 0; k < 6; k++)
                        obuf_d[k] = Z_in[6*DW-1-k*DW -: DW];
                    ridx_d  = 3'd0;
                    state_d = DRAIN;
                end else begin
                    lat_d = lat_q - 4'd1;
                end
            end
            DRAIN: begin
                if (m_ready) begin
                    if (ridx_q == 3'd5) begin
                        ridx_d  = 3'd0;
                        tcnt_d  = tcnt_q + 16'd1;
                        state_d = FILL;
                    end else begin
                        ridx_d = ridx_q + 3'd1;
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
            win_q   <= '0;
            fill_q  <= '0;
            dout_q  <= '0;
            lat_q   <= '0;
            obuf_q  <= '0;
            ridx_q  <= '0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            fill_q  <= fill_d;
            dout_q  <= dout_d;
            lat_q   <= lat_d;
            obuf_q  <= obuf_d;
            ridx_q  <= ridx_d;
            tcnt_q  <= tcnt_d;
        end
    end

endmodule

// File: tb/tb_wc_tile_streamer.sv
// Directed bench: tile vectors in a table plus hand sequences for stall, abort and streaming.
module tb_wc_tile_streamer;

    localparam int DW     = 10;
    localparam int WC_LAT = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic              s_valid;
    logic              s_ready;
    logic [DW-1:0]     s_data;
    logic              s_first;
    logic [8*DW-1:0]   D_out;
    logic [6*DW-1:0]   Z_in;
    logic              m_valid;
    logic              m_ready;
    logic [DW-1:0]     m_data;
    logic [15:0]       tile_cnt;

    int checks = 0;
    int errors = 0;

    wc_tile_streamer #(.DW(DW), .WC_LAT(WC_LAT)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_first(s_first),
        .D_out(D_out), .Z_in(Z_in),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .tile_cnt(tile_cnt)
    );

    always #5 clk = ~clk;

    // WC core stub: results 0..5 equal tile samples 0..5, WC_LAT cycles after D_out changes.
    logic [8*DW-1:0] dl [WC_LAT];
    always @(posedge clk) begin
        dl[0] <= D_out;
        for (int i = 1; i < WC_LAT; i++) dl[i] <= dl[i-1];
    end
    assign Z_in = dl[WC_LAT-1][8*DW-1 -: 6*DW];

    typedef struct packed {
        logic [3:0]       n;
        logic [14*DW-1:0] din;
        logic [13:0]      first;
        logic [8*DW-1:0]  dexp;
        logic [15:0]      tiles;
        logic [3:0]       stall;
    } vec_t;

    vec_t vec [5];

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic send(input logic [DW-1:0] d, input logic f);
        int w;
        w = 0;
        s_valid = 1'b1; s_data = d; s_first = f;
        while (!s_ready && w < 100) begin
            @(posedge clk); #1; w++;
        end
        if (w >= 100) chk("send_timeout", 80'(w), 80'(0));
        @(posedge clk); #1;
        s_valid = 1'b0; s_first = 1'b0;
    endtask

    task automatic run_tile(input vec_t v, input string tag);
        int cnt;
        logic [DW-1:0] eo;
        for (int i = 0; i < int'(v.n); i++)
            send(v.din[14*DW-1-i*DW -: DW], v.first[i]);
        chk({tag, "_dout"}, 80'(D_out), 80'(v.dexp));
        chk({tag, "_sready_wait"}, 80'(s_ready), 80'(0));
        cnt = 0;
        while (!m_valid && cnt < 50) begin
            @(posedge clk); #1; cnt++;
        end
        chk({tag, "_latency"}, 80'(cnt), 80'(WC_LAT + 1));
        for (int k = 0; k < 6; k++) begin
            eo = v.dexp[8*DW-1-k*DW -: DW];
            if (k == int'(v.stall)) begin
                m_ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    @(posedge clk); #1;
                    chk({tag, "_stall_mvalid"}, 80'(m_valid), 80'(1));
                    chk({tag, "_stall_mdata"}, 80'(m_data), 80'(eo));
                    chk({tag, "_stall_sready"}, 80'(s_ready), 80'(0));
                end
                m_ready = 1'b1;
            end
            chk({tag, "_mvalid"}, 80'(m_valid), 80'(1));
            chk({tag, "_mdata"}, 80'(m_data), 80'(eo));
            @(posedge clk); #1;
        end
        chk({tag, "_tile_cnt"}, 80'(tile_cnt), 80'(v.tiles));
        chk({tag, "_mvalid_end"}, 80'(m_valid), 80'(0));
        chk({tag, "_sready_end"}, 80'(s_ready), 80'(1));
    endtask

    initial begin
        int acc;
        int acc_at [47];
        logic hs;
        logic seen;

        vec[0].n     = 4'd8;
        vec[0].din   = {10'sd2, -10'sd10, 10'sd3, 10'sd4, -10'sd13, -10'sd18, -10'sd16, -10'sd28, {6{10'd0}}};
        vec[0].first = 14'd1;
        vec[0].dexp  = 80'b0000000010_1111110110_0000000011_0000000100_1111110011_1111101110_1111110000_1111100100;
        vec[0].tiles = 16'd1;
        vec[0].stall = 4'd15;

        vec[1].n     = 4'd6;
        vec[1].din   = {-10'sd19, -10'sd6, 10'sd3, -10'sd9, -10'sd12, 10'sd11, {8{10'd0}}};
        vec[1].first = 14'd0;
        vec[1].dexp  = {-10'sd16, -10'sd28, -10'sd19, -10'sd6, 10'sd3, -10'sd9, -10'sd12, 10'sd11};
        vec[1].tiles = 16'd2;
        vec[1].stall = 4'd15;

        vec[2].n     = 4'd6;
        vec[2].din   = {10'sd7, 10'sd8, 10'sd9, 10'sd10, 10'sd11, 10'sd12, {8{10'd0}}};
        vec[2].first = 14'd0;
        vec[2].dexp  = {-10'sd12, 10'sd11, 10'sd7, 10'sd8, 10'sd9, 10'sd10, 10'sd11, 10'sd12};
        vec[2].tiles = 16'd3;
        vec[2].stall = 4'd2;

        vec[3].n     = 4'd13;
        vec[3].din   = {10'sd100, 10'sd101, 10'sd102, 10'sd103, 10'sd104,
                        10'sd21, -10'sd22, 10'sd23, -10'sd24, 10'sd25, -10'sd26, 10'sd27, -10'sd28, 10'd0};
        vec[3].first = 14'b00000000100000;
        vec[3].dexp  = {10'sd21, -10'sd22, 10'sd23, -10'sd24, 10'sd25, -10'sd26, 10'sd27, -10'sd28};
        vec[3].tiles = 16'd4;
        vec[3].stall = 4'd15;

        vec[4].n     = 4'd8;
        vec[4].din   = {10'h1FF, 10'h200, 10'h000, 10'h3FF, 10'sd1, 10'sd100, -10'sd100, 10'sd255, {6{10'd0}}};
        vec[4].first = 14'd1;
        vec[4].dexp  = {10'h1FF, 10'h200, 10'h000, 10'h3FF, 10'sd1, 10'sd100, -10'sd100, 10'sd255};
        vec[4].tiles = 16'd1;
        vec[4].stall = 4'd15;

        s_valid = 1'b0; s_data = '0; s_first = 1'b0; m_ready = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        do_reset();

        chk("rst_sready",   80'(s_ready),  80'(1));
        chk("rst_mvalid",   80'(m_valid),  80'(0));
        chk("rst_mdata",    80'(m_data),   80'(0));
        chk("rst_tile_cnt", 80'(tile_cnt), 80'(0));
        chk("rst_dout",     80'(D_out),    80'(0));

        for (int t = 0; t < 4; t++) run_tile(vec[t], $sformatf("tile%0d", t));

        // Abort a tile with reset while the latency counter sits at 3.
        for (int i = 0; i < 8; i++) send(10'(50 + i), (i == 0));
        repeat (3) begin @(posedge clk); #1; end
        do_reset();
        chk("abort_sready",   80'(s_ready),  80'(1));
        chk("abort_mvalid",   80'(m_valid),  80'(0));
        chk("abort_tile_cnt", 80'(tile_cnt), 80'(0));
        chk("abort_dout",     80'(D_out),    80'(0));
        chk("abort_mdata",    80'(m_data),   80'(0));
        seen = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (m_valid) seen = 1'b1;
        end
        chk("abort_no_result", 80'(seen), 80'(0));
        run_tile(vec[4], "fresh");

        // Continuous input with m_ready=1: 8 accepts, 13-cycle gap, then 6 per tile.
        do_reset();
        acc = 0;
        s_valid = 1'b1; s_first = 1'b1; s_data = 10'd0;
        for (int c = 1; c <= 46; c++) begin
            hs = s_valid && s_ready;
            chk("stream_excl", 80'(s_ready && m_valid), 80'(0));
            @(posedge clk); #1;
            if (hs) begin
                acc++;
                s_data  = s_data + 10'd1;
                s_first = 1'b0;
            end
            acc_at[c] = acc;
        end
        s_valid = 1'b0;
        chk("stream_acc8",  80'(acc_at[8]),  80'(8));
        chk("stream_acc15", 80'(acc_at[15]), 80'(8));
        chk("stream_acc21", 80'(acc_at[21]), 80'(8));
        chk("stream_acc27", 80'(acc_at[27]), 80'(14));
        chk("stream_acc40", 80'(acc_at[40]), 80'(14));
        chk("stream_acc46", 80'(acc_at[46]), 80'(20));
        chk("stream_tiles", 80'(tile_cnt),   80'(2));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
